// File: rtl/regfile_writeback_ctrl.sv
// Write-back controller for the 16x32 register file: queues results in an
// in-order FIFO, drains one per cycle, and forwards pending data to readers.
module regfile_writeback_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rf_busy,
  output logic              rf_ld,
  output logic [ADDR_W-1:0] rf_sel,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rf_q_a,
  input  logic [DATA_W-1:0] rf_q_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready depends on count only, so a full FIFO never accepts, even when
  // the head entry is draining in the same cycle.
  assign in_ready = (count < FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !rf_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= in_addr;
      ent_data[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      rf_ld     <= 1'b0;
      rf_sel    <= '0;
      rf_data   <= '0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      // Pop decision uses the pre-edge count, so a push into an empty FIFO waits a cycle.
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
        rf_sel          <= ent_addr[head];
        rf_data         <= ent_data[head];
      end
      rf_ld <= pop;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins; the entry
  // currently on the rf_ld outputs is older than anything still queued.
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] q);
    logic [DATA_W-1:0] r;
    logic [PTR_W-1:0]  idx;
    r = q;
    if (rf_ld && (rf_sel == addr)) r = rf_data;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_valid[idx] && (ent_addr[idx] == addr)) r = ent_data[idx];
    end
    return r;
  endfunction

  always_comb begin
    rd_data_a = fwd(rd_addr_a, rf_q_a);
    rd_data_b = fwd(rd_addr_b, rf_q_b);
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl: expected register-file writes are
// queued at issue time and checked by a monitor whenever rf_ld is high.
module tb_regfile_writeback_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              rf_busy;
  logic              rf_ld;
  logic [ADDR_W-1:0] rf_sel;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rf_q_a;
  logic [DATA_W-1:0] rf_q_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  regfile_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_busy(rf_busy), .rf_ld(rf_ld), .rf_sel(rf_sel), .rf_data(rf_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rf_q_a(rf_q_a), .rf_q_b(rf_q_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset && rf_ld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: unexpected rf_ld sel=%0d data=%h, nothing expected", rf_sel, rf_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({rf_sel, rf_data} !== e) begin
          errors++;
          $display("FAIL rf_write: got sel=%0d data=%h, expected sel=%0d data=%h",
                   rf_sel, rf_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge; leaves the bench 1ns after that edge.
  task automatic drive_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic exp_acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_acc));
    if (exp_acc) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] s_addr [10] = '{4'd0, 4'd9, 4'd15, 4'd9, 4'd3, 4'd12, 4'd1, 4'd9, 4'd6, 4'd15};

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_addr = 4'd3; in_data = 32'hFFFF_FFFF;
    rf_busy = 1'b0; rd_addr_a = '0; rd_addr_b = '0; rf_q_a = '0; rf_q_b = '0;

    // Reset state held with in_valid asserted
    step(); step();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_rf_ld",    64'(rf_ld),    64'd0);
    check("reset_rf_sel",   64'(rf_sel),   64'd0);
    check("reset_rf_data",  64'(rf_data),  64'd0);
    check("reset_count",    64'(count),    64'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();

    // First-transaction latency
    drive_req(4'd3, 32'hA5A5_A5A5, 1'b1);
    check("lat_edge1_rf_ld", 64'(rf_ld), 64'd0);
    check("lat_edge1_count", 64'(count), 64'd1);
    step();
    check("lat_edge2_rf_ld",   64'(rf_ld),   64'd1);
    check("lat_edge2_rf_sel",  64'(rf_sel),  64'd3);
    check("lat_edge2_rf_data", 64'(rf_data), 64'hA5A5_A5A5);
    check("lat_edge2_count",   64'(count),   64'd0);
    step();
    check("lat_edge3_rf_ld", 64'(rf_ld), 64'd0);

    // Full / backpressure
    rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) drive_req(ADDR_W'(i), DATA_W'(i * 32'h11), 1'b1);
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive_req(4'd5, 32'h55, 1'b0);
    check("full_count_after_reject", 64'(count), 64'd4);
    check("busy_no_ld", 64'(rf_ld), 64'd0);
    rf_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_rf_ld", 64'(rf_ld), 64'd1);
    end
    check("drain_count", 64'(count), 64'd0);
    step();
    check("drain_done_rf_ld", 64'(rf_ld), 64'd0);

    // Forwarding priority
    rf_busy = 1'b1;
    drive_req(4'd5, 32'h100, 1'b1);
    drive_req(4'd5, 32'h200, 1'b1);
    rf_q_a = 32'hDEAD; rf_q_b = 32'hDEAD; rd_addr_a = 4'd5; rd_addr_b = 4'd6;
    #1;
    check("fwd_youngest_a", 64'(rd_data_a), 64'h200);
    check("fwd_nomatch_b",  64'(rd_data_b), 64'hDEAD);
    rd_addr_b = 4'd5;
    #1;
    check("fwd_youngest_b", 64'(rd_data_b), 64'h200);
    rf_busy = 1'b0;
    step();
    check("fwd_queue_over_ld", 64'(rd_data_a), 64'h200);
    step();
    check("fwd_ld_entry", 64'(rd_data_a), 64'h200);
    step();
    check("fwd_retired", 64'(rd_data_a), 64'hDEAD);

    // In-flight forward; same-cycle push is not forwarded
    rd_addr_a = 4'd7; rf_q_a = '0; rd_addr_b = 4'd0; rf_q_b = 32'hBEEF;
    in_valid = 1'b1; in_addr = 4'd7; in_data = 32'h77;
    #1;
    check("in_ready_7", 64'(in_ready), 64'd1);
    check("fwd_same_cycle_push", 64'(rd_data_a), 64'h0);
    exp_q.push_back({4'd7, 32'h77});
    step();
    in_valid = 1'b0;
    #1;
    check("fwd_queued_7", 64'(rd_data_a), 64'h77);
    step();
    check("inflight_rf_ld", 64'(rf_ld), 64'd1);
    check("fwd_inflight_7", 64'(rd_data_a), 64'h77);
    check("fwd_port_b_raw", 64'(rd_data_b), 64'hBEEF);
    step();
    check("fwd_after_retire", 64'(rd_data_a), 64'h0);
    rf_q_a = 32'h1234;
    #1;
    check("fwd_follows_rf_q", 64'(rd_data_a), 64'h1234);

    // Streaming push/pop with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive_req(s_addr[i], 32'h1000 + 32'(i), 1'b1);
      check("stream_count", 64'(count), 64'd1);
    end
    step();
    check("stream_end_count", 64'(count), 64'd0);
    step();
    check("stream_end_rf_ld", 64'(rf_ld), 64'd0);
    check("stream_all_written", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation
    rf_busy = 1'b1;
    drive_req(4'd2, 32'h2222, 1'b1);
    drive_req(4'd8, 32'h8888, 1'b1);
    drive_req(4'd2, 32'h2D2D, 1'b1);
    check("pre_reset_count", 64'(count), 64'd3);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_count",    64'(count),    64'd0);
    check("midreset_rf_ld",    64'(rf_ld),    64'd0);
    check("midreset_rf_sel",   64'(rf_sel),   64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    #1;
    reset = 1'b1;
    rf_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_no_ld", 64'(rf_ld), 64'd0);
    end
    check("post_reset_count", 64'(count), 64'd0);
    step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
Write-side initiator for the 16x32 register file. It accepts write-back results over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file's load-enable, select and data inputs. It also forwards pending (not-yet-written) data to the two read ports, so readers never see stale register contents.

Parameters:
DATA_W, 32, register data width
ADDR_W, 4, register select width (2**ADDR_W registers)
DEPTH, 4, FIFO entries; must be a power of 2, >= 2

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  write-back request valid
in_ready  output  1  controller can accept a request
in_addr  input  ADDR_W  destination register
in_data  input  DATA_W  value to write
rf_busy  input  1  register file cannot accept a write this cycle
rf_ld  output  1  register file load enable (decoder enable)
rf_sel  output  ADDR_W  register file write select (decoder input)
rf_data  output  DATA_W  register file write data
rd_addr_a  input  ADDR_W  read port A select (also drives mux A)
rd_addr_b  input  ADDR_W  read port B select (also drives mux B)
rf_q_a  input  DATA_W  raw register file mux A output
rf_q_b  input  DATA_W  raw register file mux B output
rd_data_a  output  DATA_W  forwarded read data, port A
rd_data_b  output  DATA_W  forwarded read data, port B
count  output  clog2(DEPTH+1)  number of FIFO entries held

Behaviour:
- Reset (reset=0, asynchronous) clears the following: count=0, head and tail pointers=0, rf_ld=0, rf_sel=0, rf_data=0, all entry valid bits=0.
- Reset mid-operation discards all queued entries. No rf_ld pulse is issued for them.
- in_ready = (count < DEPTH). It is combinational from count only; there is no pass-through when full.
- Push: in_valid && in_ready at a rising edge writes {in_addr, in_data} at tail. tail then advances modulo DEPTH.
- Pop: at a rising edge with count>0 && !rf_busy, the head entry is loaded into the rf_sel/rf_data registers and rf_ld<=1. head then advances modulo DEPTH.
- If there is no pop at an edge: rf_ld<=0, and rf_sel/rf_data hold their previous values.
- rf_ld is high for exactly one cycle per popped entry.
- Back-to-back pops give consecutive rf_ld cycles with new sel/data each cycle.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO is not popped at the same edge.
- Latency: a request accepted at edge N drives rf_ld=1 after edge N+1 (earliest). The register file captures the value at edge N+2.
- Ordering is strictly FIFO. Repeated writes to the same address are all issued, in order.
- rf_busy high stalls draining only. Pushes continue until the FIFO is full.
- Forwarding (combinational, independent per port): candidates are valid FIFO entries plus the current rf_ld output entry when rf_ld=1.
  - Result = data of the youngest candidate whose address equals rd_addr_x.
  - Age order, youngest first: tail-1 ... head, then the rf_ld entry.
  - If no candidate matches: rd_data_x = rf_q_x.
  - The request being pushed this same cycle is not forwarded.
- All 2**ADDR_W registers are writable. There is no hardwired zero register.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> in_ready=1, rf_ld=0, rf_sel=0, rf_data=0, count=0. Release; push {3, 0xA5A5A5A5} at edge 1 -> rf_ld=1, rf_sel=3, rf_data=0xA5A5A5A5 after edge 2 only.
- Full/backpressure: rf_busy=1; push addrs 1,2,3,4 with data 0x11..0x44 -> count=4, in_ready=0, a 5th request is not accepted. Drop rf_busy -> rf_ld high four consecutive cycles with sel 1,2,3,4 in order, then count=0.
- Forwarding priority: rf_busy=1; push {5, 0x100} then {5, 0x200}; rf_q_a=0xDEAD, rd_addr_a=5 -> rd_data_a=0x200. With rd_addr_b=6 -> rd_data_b=0xDEAD.
- In-flight forward: single push {7, 0x77}; in the cycle rf_ld=1 with rd_addr_a=7 and rf_q_a=0 -> rd_data_a=0x77. The next cycle (entry retired) -> rd_data_a follows rf_q_a.
- Simultaneous push/pop and wrap: stream 10 requests back-to-back with rf_busy=0 -> count stays at 1 in steady state. All 10 appear on rf_ld in order, pointers wrap past DEPTH, no loss or duplication.
- Reset mid-operation: 3 entries queued, rf_busy=1; pulse reset low between edges -> count=0 immediately, rf_ld=0. No pulses appear after release.
